bus_arbiter_mm: RTL and testbench
=================================

Name: bus_arbiter_mm

Overview:
Parametrised multi-master shared-bus controller, next generation of the two-requester tristate bus. M masters share one N-bit registered broadcast bus through a mux; no internal tristates. Arbitration is fixed-priority or round-robin, selected by parameter. A hold limit stops one master from owning the bus indefinitely. Sits between peripheral masters and the shared data path.

Parameters:
N, 8, bus data width in bits (>=1)
M, 4, number of masters (2..16)
MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
MAX_HOLD, 4, max consecutive grant cycles while another master waits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  M  per-master request, level-sensitive
data_in  input  M*N  master k drives bits [k*N+N-1 : k*N]
grant  output  M  one-hot registered grant; all-zero when idle
bus_data  output  N  registered bus value
bus_valid  output  1  high when bus_data carries an owner's data
src_id  output  clog2(M) (min 1)  index of current owner; holds last owner when idle

Behaviour:
- Reset (rst=0, async): grant=0, bus_data=0, bus_valid=0, src_id=0, hold_cnt=0, rr_ptr=0, state=IDLE. Outputs stay at these values while rst=0.
- States: IDLE (no owner), OWN (one owner). All outputs are registered.
- Winner selection, combinational, evaluated every cycle:
  - MODE 0: lowest-index requester.
  - MODE 1: first requester scanning rr_ptr, rr_ptr+1, ... mod M.
- IDLE: if req!=0, at the next edge grant<=onehot(winner), src_id<=winner, state<=OWN, hold_cnt<=1. Otherwise stay idle.
- OWN, owner o, evaluated at each edge:
  - req[o]=0: if any other master requests, switch to the winner with no idle cycle and set hold_cnt=1. Otherwise go to IDLE and set grant=0.
  - req[o]=1 and hold_cnt<MAX_HOLD: keep o and increment hold_cnt.
  - req[o]=1 and hold_cnt>=MAX_HOLD, others requesting: preempt. The winner is chosen with o excluded (MODE 0: lowest other index; MODE 1: scan from o+1). Set hold_cnt=1.
  - req[o]=1 and hold_cnt>=MAX_HOLD, no others requesting: keep o, hold_cnt saturates at MAX_HOLD.
- rr_ptr: on every new grant to master k (including a re-grant from IDLE), rr_ptr<=(k+1) mod M. MODE 0 ignores rr_ptr.
- Data path: on the same edge that grant is updated, bus_data<=data_in slice of the newly granted master and bus_valid<=1. Each cycle in OWN, bus_data tracks the owner's slice, sampled one cycle late. When entering IDLE, bus_valid<=0 and bus_data<=0.
- Timing: latency is 1 cycle from req to grant/bus_data. A handover never produces a bus_valid gap when another requester is pending.
- The grant is at most one-hot in every cycle. No X on outputs after reset.
- req changing during reset has no effect. Arbitration starts from rr_ptr=0 on the first edge after rst rises.

Test Plan:
- Reset: rst=0 with req=4'b1111 -> grant=0, bus_valid=0, bus_data=00. After release, first edge gives grant=0001, src_id=0.
- Single master: req=0100, data_in slice2=AA -> one edge later grant=0100, bus_data=AA, bus_valid=1. Change slice2 to E5 -> bus_data=E5 one cycle later. Drop req -> next edge grant=0, bus_valid=0, bus_data=00.
- Round-robin rotation, MODE=1: req=1111 held, each master's req dropped after 1 grant cycle then re-raised -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle.
- Hold limit, MODE=1, MAX_HOLD=4: req[1] held from t0, req[3] raised at cycle 1 -> grant=0010 for exactly 4 cycles, then 1000. If req[1] is still high, it wins again after master 3's 4 cycles.
- Fixed priority, MODE=0: req=0110 held -> grant=0010 for 4 cycles, preempted to 0100 for 4 cycles, back to 0010. req[0] raised mid-tenure -> master 0 gets the bus at the next release or preemption point.
- Async reset mid-tenure: while grant=0100, pull rst low between clock edges -> grant, bus_valid and bus_data clear immediately without waiting for clk. After release with req=0100 held, grant=0100 reappears one edge later.

Source files
------------

// File: rtl/bus_arbiter_mm.sv
// bus_arbiter_mm
//   Multi-master shared-bus controller. M masters share one N-bit registered
//   broadcast bus through a mux (no tristates). The owner is picked by fixed
//   priority (MODE 0, lowest index wins) or round-robin (MODE 1, scan from
//   rr_ptr). A hold limit of MAX_HOLD consecutive cycles hands the bus to
//   another requester when one is waiting.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req        per-master request, level-sensitive
//   data_in    master k drives bits [k*N+N-1 : k*N]
//   grant      one-hot registered grant, all-zero when idle
//   bus_data   registered bus value (owner's slice, one cycle late)
//   bus_valid  high while bus_data carries an owner's data
//   src_id     index of the current owner; holds the last owner when idle
module bus_arbiter_mm #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [M-1:0]                         req,
  input  logic [M*N-1:0]                       data_in,
  output logic [M-1:0]                         grant,
  output logic [N-1:0]                         bus_data,
  output logic                                 bus_valid,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] src_id
);

  localparam int SW = (M > 1) ? $clog2(M) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [SW:0]   M_W        = (SW+1)'(M);
  localparam logic [SW-1:0] LAST_IDX   = SW'(M - 1);
  localparam logic [HW-1:0] HOLD_MAX_W = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] rr_ptr;

  logic [M-1:0]  own_bit;
  logic          owner_req;
  logic          excl_owner;
  logic [M-1:0]  sel_mask;
  logic [SW-1:0] sel_start;
  logic          sel_found;
  logic [SW:0]   scan;
  logic [SW-1:0] win_idx;

  logic [0:0]    nxt_state;
  logic [SW-1:0] nxt_owner;
  logic [HW-1:0] nxt_hold;
  logic          new_grant;
  logic [N-1:0]  nxt_data;

  function automatic logic [SW-1:0] inc_mod(input logic [SW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + SW'(1);
  endfunction

  assign own_bit   = M'(1) << src_id;
  assign owner_req = |(req & own_bit);

  // While the owner still requests, the only reason to pick a winner is a
  // preemption, so the owner is masked out and the scan starts just past it.
  assign excl_owner = (state == OWN) && owner_req;
  assign sel_mask   = excl_owner ? (req & ~own_bit) : req;
  assign sel_found  = |sel_mask;

  always_comb begin
    sel_start = '0;
    if (MODE != 0) begin
      sel_start = excl_owner ? inc_mod(src_id) : rr_ptr;
    end
  end

  // Scan offsets from high to low so the lowest offset that hits is the last
  // one assigned, i.e. the first requester found from sel_start.
  always_comb begin
    win_idx = '0;
    scan    = '0;
    for (int i = M - 1; i >= 0; i--) begin
      scan = {1'b0, sel_start} + (SW+1)'(i);
      if (scan >= M_W) begin
        scan = scan - M_W;
      end
      if (sel_mask[scan[SW-1:0]]) begin
        win_idx = scan[SW-1:0];
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = src_id;
    nxt_hold  = hold_cnt;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          nxt_state = OWN;
          nxt_owner = win_idx;
          nxt_hold  = HOLD_ONE;
          new_grant = 1'b1;
        end
      end
      default: begin
        if (!owner_req) begin
          if (sel_found) begin
            // Direct handover, no idle cycle between owners.
            nxt_owner = win_idx;
            nxt_hold  = HOLD_ONE;
            new_grant = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_hold  = '0;
          end
        end else if (hold_cnt < HOLD_MAX_W) begin
          nxt_hold = hold_cnt + HOLD_ONE;
        end else if (sel_found) begin
          nxt_owner = win_idx;
          nxt_hold  = HOLD_ONE;
          new_grant = 1'b1;
        end else begin
          // Nobody else waiting: keep the owner, counter stays saturated.
          nxt_hold = HOLD_MAX_W;
        end
      end
    endcase
  end

  always_comb begin
    nxt_data = '0;
    if (nxt_state == OWN) begin
      for (int k = 0; k < M; k++) begin
        if (nxt_owner == SW'(k)) begin
          nxt_data = data_in[k*N +: N];
        end
      end
    end
  end

  // Register stage: control and the bus data path update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rr_ptr    <= '0;
      src_id    <= '0;
      grant     <= '0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
    end else begin
      state     <= nxt_state;
      hold_cnt  <= nxt_hold;
      src_id    <= nxt_owner;
      grant     <= (nxt_state == OWN) ? (M'(1) << nxt_owner) : '0;
      bus_valid <= (nxt_state == OWN);
      bus_data  <= nxt_data;
      if (new_grant) begin
        rr_ptr <= inc_mod(nxt_owner);
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mm.sv
module tb_bus_arbiter_mm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [3:0]  req_rr = 4'b0000;
  logic [3:0]  req_fp = 4'b0000;
  logic [31:0] din = 32'h0;

  logic [3:0]  grant_rr, grant_fp;
  logic [7:0]  data_rr, data_fp;
  logic        valid_rr, valid_fp;
  logic [1:0]  src_rr, src_fp;

  int checks = 0;
  int errors = 0;

  bus_arbiter_mm #(.N(8), .M(4), .MODE(1), .MAX_HOLD(4)) dut_rr (
    .clk(clk), .rst(rst), .req(req_rr), .data_in(din),
    .grant(grant_rr), .bus_data(data_rr), .bus_valid(valid_rr), .src_id(src_rr)
  );

  bus_arbiter_mm #(.N(8), .M(4), .MODE(0), .MAX_HOLD(4)) dut_fp (
    .clk(clk), .rst(rst), .req(req_fp), .data_in(din),
    .grant(grant_fp), .bus_data(data_fp), .bus_valid(valid_fp), .src_id(src_fp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with every master requesting.
    req_rr = 4'b1111;
    tick(); tick();
    chk("rst_grant", 32'(grant_rr), 32'h0);
    chk("rst_valid", 32'(valid_rr), 32'h0);
    chk("rst_data",  32'(data_rr),  32'h0);
    chk("rst_src",   32'(src_rr),   32'h0);
    chk("rst_grant_fp", 32'(grant_fp), 32'h0);

    rst = 1'b1;
    tick();
    chk("first_grant", 32'(grant_rr), 32'h1);
    chk("first_src",   32'(src_rr),   32'h0);
    chk("first_valid", 32'(valid_rr), 32'h1);

    req_rr = 4'b0000;
    tick();
    chk("release_idle", 32'(grant_rr), 32'h0);
    chk("release_valid", 32'(valid_rr), 32'h0);

    // Single master on slice 2.
    din = 32'h00AA_0000;
    req_rr = 4'b0100;
    tick();
    chk("single_grant", 32'(grant_rr), 32'h4);
    chk("single_data",  32'(data_rr),  32'hAA);
    chk("single_valid", 32'(valid_rr), 32'h1);
    chk("single_src",   32'(src_rr),   32'h2);
    din = 32'h00E5_0000;
    tick();
    chk("single_track", 32'(data_rr), 32'hE5);
    req_rr = 4'b0000;
    tick();
    chk("single_drop_grant", 32'(grant_rr), 32'h0);
    chk("single_drop_valid", 32'(valid_rr), 32'h0);
    chk("single_drop_data",  32'(data_rr),  32'h0);

    // Round-robin rotation from a fresh pointer.
    din = 32'h4433_2211;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_rr = 4'b1111;
    tick();
    chk("rot0_grant", 32'(grant_rr), 32'h1);
    chk("rot0_data",  32'(data_rr),  32'h11);
    req_rr = 4'b1110;
    tick();
    chk("rot1_grant", 32'(grant_rr), 32'h2);
    chk("rot1_data",  32'(data_rr),  32'h22);
    chk("rot1_valid", 32'(valid_rr), 32'h1);
    req_rr = 4'b1101;
    tick();
    chk("rot2_grant", 32'(grant_rr), 32'h4);
    chk("rot2_valid", 32'(valid_rr), 32'h1);
    req_rr = 4'b1011;
    tick();
    chk("rot3_grant", 32'(grant_rr), 32'h8);
    chk("rot3_data",  32'(data_rr),  32'h44);
    req_rr = 4'b0111;
    tick();
    chk("rot4_grant", 32'(grant_rr), 32'h1);
    chk("rot4_valid", 32'(valid_rr), 32'h1);

    req_rr = 4'b0000;
    tick();
    chk("rot_idle", 32'(grant_rr), 32'h0);

    // Hold limit, round-robin: master 1 then master 3 then master 1 again.
    req_rr = 4'b0010;
    tick();
    chk("hold_m1_first", 32'(grant_rr), 32'h2);
    chk("hold_m1_data",  32'(data_rr),  32'h22);
    req_rr = 4'b1010;
    repeat (3) begin
      tick();
      chk("hold_m1", 32'(grant_rr), 32'h2);
    end
    tick();
    chk("hold_pre_m3",   32'(grant_rr), 32'h8);
    chk("hold_pre_data", 32'(data_rr),  32'h44);
    chk("hold_pre_valid", 32'(valid_rr), 32'h1);
    repeat (3) begin
      tick();
      chk("hold_m3", 32'(grant_rr), 32'h8);
    end
    tick();
    chk("hold_back_m1",  32'(grant_rr), 32'h2);
    chk("hold_back_src", 32'(src_rr),   32'h1);

    req_rr = 4'b0000;
    tick();
    chk("hold_idle", 32'(grant_rr), 32'h0);

    // Fixed priority: 1 and 2 alternate in four-cycle tenures, 0 wins at preemption.
    req_fp = 4'b0110;
    tick();
    chk("fp_m1_first", 32'(grant_fp), 32'h2);
    chk("fp_m1_data",  32'(data_fp),  32'h22);
    repeat (3) begin
      tick();
      chk("fp_m1", 32'(grant_fp), 32'h2);
    end
    tick();
    chk("fp_pre_m2",   32'(grant_fp), 32'h4);
    chk("fp_pre_data", 32'(data_fp),  32'h33);
    repeat (3) begin
      tick();
      chk("fp_m2", 32'(grant_fp), 32'h4);
    end
    tick();
    chk("fp_back_m1", 32'(grant_fp), 32'h2);
    req_fp = 4'b0111;
    repeat (3) begin
      tick();
      chk("fp_m1_hold", 32'(grant_fp), 32'h2);
    end
    tick();
    chk("fp_m0_grant", 32'(grant_fp), 32'h1);
    chk("fp_m0_src",   32'(src_fp),   32'h0);
    chk("fp_m0_data",  32'(data_fp),  32'h11);
    req_fp = 4'b0000;

    // Sole requester keeps the bus past the hold limit, then async reset mid-tenure.
    req_rr = 4'b0100;
    tick();
    chk("sat_first", 32'(grant_rr), 32'h4);
    repeat (5) begin
      tick();
      chk("sat_keep", 32'(grant_rr), 32'h4);
    end
    chk("sat_data", 32'(data_rr), 32'h33);
    #2 rst = 1'b0;
    #1;
    chk("async_grant", 32'(grant_rr), 32'h0);
    chk("async_valid", 32'(valid_rr), 32'h0);
    chk("async_data",  32'(data_rr),  32'h0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant_rr), 32'h4);
    chk("post_rst_valid", 32'(valid_rr), 32'h1);
    chk("post_rst_src",   32'(src_rr),   32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
